encap_result_reader: RTL



---
 rtl/encap_io_pkg.sv | 26 ++
 rtl/encap_result_reader_if.sv | 28 ++
 rtl/encap_result_reader_word_byte_serializer.sv | 42 ++++
 rtl/encap_result_reader.sv | 114 +++++++++++
 4 files changed

// File: rtl/encap_io_pkg.sv
// encap_io_pkg: shared parameter-set lookup, C0 sizing and encodings for the encap result reader
package encap_io_pkg;

   typedef enum logic [1:0] {SEC_C0, SEC_C1, SEC_K} sec_e;
   typedef enum logic [2:0] {IDLE, ISSUE, LOAD, SEND, FINISH} state_e;

   localparam int C1_WORDS = 8;
   localparam int K_WORDS  = 8;

   function automatic int mc_m(input int ps);
      return (ps == 1) ? 12 : 13;
   endfunction

   function automatic int mc_t(input int ps);
      return (ps == 1) ? 64 : (ps == 2) ? 96 : (ps == 4) ? 119 : 128;
   endfunction

   function automatic int words_of(input int bits);
      return (bits + 31) / 32;
   endfunction

   function automatic int bytes_of(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/encap_result_reader_if.sv
// encap_result_reader_if: control, result-memory read ports and UART byte stream of the reader
interface encap_result_reader_if #(parameter int AW = 5);
   logic          start;
   logic          busy;
   logic          done;
   logic          rd_C0;
   logic [AW-1:0] C0_addr;
   logic [31:0]   C0_out;
   logic          rd_C1;
   logic [2:0]    C1_addr;
   logic [31:0]   C1_out;
   logic          rd_K;
   logic [2:0]    K_addr;
   logic [31:0]   K_out;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;

   modport master (
      input  start, C0_out, C1_out, K_out, tx_ready,
      output busy, done, rd_C0, C0_addr, rd_C1, C1_addr, rd_K, K_addr, tx_data, tx_valid
   );

   modport slave (
      output start, C0_out, C1_out, K_out, tx_ready,
      input  busy, done, rd_C0, C0_addr, rd_C1, C1_addr, rd_K, K_addr, tx_data, tx_valid
   );
endinterface

// File: rtl/encap_result_reader_word_byte_serializer.sv
// word_byte_serializer: holds one 32-bit word and hands out 1..4 bytes LSB first over valid/ready
module word_byte_serializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [31:0] i_word,
   input  logic [2:0]  i_count,
   input  logic        i_ready,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_last
);

   logic [31:0] r_word;
   logic [1:0]  r_left;
   logic        r_valid;
   logic        w_fire;

   assign w_fire = r_valid && i_ready;

   // load a word, then drop one byte per handshake; a stall freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word  <= '0;
         r_left  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_word  <= i_word;
         r_left  <= 2'(i_count - 3'd1);
         r_valid <= 1'b1;
      end else if (w_fire) begin
         r_word  <= r_word >> 8;
         r_left  <= r_left - 2'd1;
         r_valid <= (r_left != 2'd0);
      end
   end

   assign o_data  = r_word[7:0];
   assign o_valid = r_valid;
   assign o_last  = (r_left == 2'd0);

endmodule

// File: rtl/encap_result_reader.sv
// encap_result_reader: drains C0, C1 then K result memories and streams them out as bytes
module encap_result_reader
   import encap_io_pkg::*;
#(
   parameter int parameter_set = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   encap_result_reader_if.master bus
);

   localparam int m        = mc_m(parameter_set);
   localparam int t        = mc_t(parameter_set);
   localparam int l        = m * t;
   localparam int C0_WORDS = words_of(l);
   localparam int C0_BYTES = bytes_of(l);
   localparam int C0_AW    = $clog2(C0_WORDS);
   localparam int C0_LAST  = C0_BYTES - 4 * (C0_WORDS - 1);

   state_e             r_state, w_state_nx;
   sec_e               r_sec, w_sec_nx;
   logic [C0_AW-1:0]   r_idx, w_idx_nx, w_last_idx;
   logic [C0_AW-1:0]   r_C0_addr;
   logic [2:0]         r_C1_addr, r_K_addr;
   logic [2:0]         w_count;
   logic [31:0]        w_rdata;
   logic               w_load, w_valid, w_last, w_word_end;

   assign w_last_idx = (r_sec == SEC_C0) ? C0_AW'(C0_WORDS - 1) :
                       (r_sec == SEC_C1) ? C0_AW'(C1_WORDS - 1) : C0_AW'(K_WORDS - 1);
   assign w_count    = (r_sec == SEC_C0 && r_idx == C0_AW'(C0_WORDS - 1)) ? 3'(C0_LAST) : 3'd4;
   assign w_rdata    = (r_sec == SEC_C0) ? bus.C0_out : (r_sec == SEC_C1) ? bus.C1_out : bus.K_out;
   assign w_word_end = w_valid && bus.tx_ready && w_last;

   // next state: walk words within a section, then sections C0 -> C1 -> K
   always_comb begin
      w_state_nx = r_state;
      w_sec_nx   = r_sec;
      w_idx_nx   = r_idx;
      w_load     = 1'b0;
      case (r_state)
         IDLE:
            if (bus.start) begin
               w_state_nx = ISSUE;
               w_sec_nx   = SEC_C0;
               w_idx_nx   = '0;
            end
         ISSUE: w_state_nx = LOAD;
         LOAD: begin
            w_state_nx = SEND;
            w_load     = 1'b1;
         end
         SEND:
            if (w_word_end) begin
               if (r_idx != w_last_idx) begin
                  w_state_nx = ISSUE;
                  w_idx_nx   = r_idx + 1'b1;
               end else if (r_sec == SEC_K) begin
                  w_state_nx = FINISH;
               end else begin
                  w_state_nx = ISSUE;
                  w_idx_nx   = '0;
                  w_sec_nx   = (r_sec == SEC_C0) ? SEC_C1 : SEC_K;
               end
            end
         FINISH: w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // state and addressing; a section's address only moves on entry to ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_sec     <= SEC_C0;
         r_idx     <= '0;
         r_C0_addr <= '0;
         r_C1_addr <= '0;
         r_K_addr  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_sec   <= w_sec_nx;
         r_idx   <= w_idx_nx;
         if (w_state_nx == ISSUE) begin
            if (w_sec_nx == SEC_C0) r_C0_addr <= w_idx_nx;
            else if (w_sec_nx == SEC_C1) r_C1_addr <= w_idx_nx[2:0];
            else r_K_addr <= w_idx_nx[2:0];
         end
      end
   end

   word_byte_serializer u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_word  (w_rdata),
      .i_count (w_count),
      .i_ready (bus.tx_ready),
      .o_data  (bus.tx_data),
      .o_valid (w_valid),
      .o_last  (w_last)
   );

   assign bus.tx_valid = w_valid;
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = (r_state == FINISH);
   assign bus.rd_C0    = (r_state == ISSUE) && (r_sec == SEC_C0);
   assign bus.rd_C1    = (r_state == ISSUE) && (r_sec == SEC_C1);
   assign bus.rd_K     = (r_state == ISSUE) && (r_sec == SEC_K);
   assign bus.C0_addr  = r_C0_addr;
   assign bus.C1_addr  = r_C1_addr;
   assign bus.K_addr   = r_K_addr;

endmodule
